// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time and hands each word to
// the instruction register over valid/ready. Define FETCH_TIMEOUT_EN to add the sticky timeout.
module instruction_fetch_unit #(
  parameter int unsigned           WORD_SIZE      = 19,
  parameter int unsigned           ADDR_WIDTH     = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  output logic [WORD_SIZE-1:0]  INSTR,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetch_error
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StValid
`ifdef FETCH_TIMEOUT_EN
    , StError
`endif
  } state_e;

  state_e                state_q;
  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
`else
  assign fetch_error = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      pc          <= RESET_PC;
      mem_addr    <= RESET_PC;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      INSTR       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= '0;
      fetch_error <= 1'b0;
`endif
    end else begin
`ifdef FETCH_TIMEOUT_EN
      // Only an ack-less, jump-less FETCH cycle keeps the count alive.
      cnt_q <= '0;
`endif
      unique case (state_q)
        StIdle: begin
          if (jump) pc <= jump_addr;
          if (enable) begin
            state_q  <= StFetch;
            mem_req  <= 1'b1;
            mem_addr <= jump ? jump_addr : pc;
          end
        end
        StFetch: begin
          if (mem_ack) begin
            if (jump || pend_q) begin
              // Redirected while in flight: drop the data, reissue at the newest target.
              pc       <= jump ? jump_addr : pend_addr_q;
              mem_addr <= jump ? jump_addr : pend_addr_q;
              pend_q   <= 1'b0;
            end else begin
              INSTR       <= mem_rdata;
              instr_valid <= 1'b1;
              pc          <= pc + ADDR_WIDTH'(1);
              mem_req     <= 1'b0;
              state_q     <= StValid;
            end
          end else if (jump) begin
            pend_q      <= 1'b1;
            pend_addr_q <= jump_addr;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            mem_req     <= 1'b0;
            fetch_error <= 1'b1;
            pend_q      <= 1'b0;
            state_q     <= StError;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        StValid: begin
          if (jump || instr_ready) begin
            instr_valid <= 1'b0;
            if (jump) pc <= jump_addr;
            if (enable) begin
              state_q  <= StFetch;
              mem_req  <= 1'b1;
              mem_addr <= jump ? jump_addr : pc;
            end else begin
              state_q <= StIdle;
            end
          end
        end
`ifdef FETCH_TIMEOUT_EN
        StError: state_q <= StError;
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a cycle table plus hand sequences for PC wrap,
// asynchronous reset and memory timeout. Honours FETCH_TIMEOUT_EN for the timeout expectations.
module tb_instruction_fetch_unit;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        enable = 1'b0, jump = 1'b0, mem_ack = 1'b0, instr_ready = 1'b0;
  logic [11:0] jump_addr = '0;
  logic [18:0] mem_rdata = '0;

  logic        mem_req, instr_valid, fetch_error;
  logic [11:0] mem_addr, pc;
  logic [18:0] INSTR;
  logic        w_mem_req, w_instr_valid, w_fetch_error;
  logic [11:0] w_mem_addr, w_pc;
  logic [18:0] w_INSTR;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  instruction_fetch_unit #(.WORD_SIZE(19), .ADDR_WIDTH(12), .RESET_PC(12'h000),
                           .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .jump(jump), .jump_addr(jump_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .INSTR(INSTR), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .fetch_error(fetch_error)
  );

  instruction_fetch_unit #(.WORD_SIZE(19), .ADDR_WIDTH(12), .RESET_PC(12'hFFF),
                           .TIMEOUT_CYCLES(16)) dut_wrap (
    .CLK(CLK), .RST(RST), .enable(enable), .jump(jump), .jump_addr(jump_addr),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .INSTR(w_INSTR), .instr_valid(w_instr_valid), .instr_ready(instr_ready), .pc(w_pc),
    .fetch_error(w_fetch_error)
  );

  typedef struct {
    logic        en;
    logic        jmp;
    logic [11:0] jaddr;
    logic        ack;
    logic [18:0] rdata;
    logic        rdy;
    logic        req;
    logic [11:0] addr;
    logic        vld;
    logic [18:0] instr;
    logic [11:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic en, input logic jmp, input logic [11:0] jaddr, input logic ack,
                   input logic [18:0] rdata, input logic rdy, input logic req,
                   input logic [11:0] addr, input logic vld, input logic [18:0] instr,
                   input logic [11:0] epc);
    vec_t r;
    r.en = en; r.jmp = jmp; r.jaddr = jaddr; r.ack = ack; r.rdata = rdata; r.rdy = rdy;
    r.req = req; r.addr = addr; r.vld = vld; r.instr = instr; r.pc = epc;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic jmp, input logic [11:0] jaddr,
                       input logic ack, input logic [18:0] rdata, input logic rdy);
    @(negedge CLK);
    enable = en; jump = jmp; jump_addr = jaddr; mem_ack = ack; mem_rdata = rdata;
    instr_ready = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    enable = 1'b0; jump = 1'b0; jump_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    instr_ready = 1'b0;
    #1;
    check("rst.mem_req", 32'(mem_req), 32'(1'b0));
    check("rst.mem_addr", 32'(mem_addr), 32'(12'h000));
    check("rst.instr_valid", 32'(instr_valid), 32'(1'b0));
    check("rst.INSTR", 32'(INSTR), 32'(19'h0));
    check("rst.pc", 32'(pc), 32'(12'h000));
    check("rst.fetch_error", 32'(fetch_error), 32'(1'b0));
    check("rst.wrap_pc", 32'(w_pc), 32'(12'hFFF));
    check("rst.wrap_mem_addr", 32'(w_mem_addr), 32'(12'hFFF));
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    //  en jmp jaddr    ack rdata     rdy | req addr     vld instr     pc
    v(H, L, 12'h000, L, 19'h00000, L,   H, 12'h000, L, 19'h00000, 12'h000); // first fetch
    v(H, L, 12'h000, H, 19'h1ABCD, L,   L, 12'h000, H, 19'h1ABCD, 12'h001);
    for (int i = 0; i < 5; i++)                                               // backpressure
      v(H, L, 12'h000, L, 19'h7FFFF, L, L, 12'h000, H, 19'h1ABCD, 12'h001);
    v(H, L, 12'h000, L, 19'h00000, H,   H, 12'h001, L, 19'h1ABCD, 12'h001);
    v(H, L, 12'h000, H, 19'h12345, H,   L, 12'h001, H, 19'h12345, 12'h002);
    v(L, L, 12'h000, L, 19'h00000, H,   L, 12'h001, L, 19'h12345, 12'h002); // to IDLE
    v(L, L, 12'h000, H, 19'h55555, L,   L, 12'h001, L, 19'h12345, 12'h002); // stray ack
    v(L, H, 12'h200, L, 19'h00000, L,   L, 12'h001, L, 19'h12345, 12'h200); // IDLE jump
    v(H, L, 12'h000, L, 19'h00000, L,   H, 12'h200, L, 19'h12345, 12'h200);
    v(L, L, 12'h000, L, 19'h00000, L,   H, 12'h200, L, 19'h12345, 12'h200); // enable drop
    v(L, L, 12'h000, H, 19'h0AAAA, L,   L, 12'h200, H, 19'h0AAAA, 12'h201);
    v(H, H, 12'h100, L, 19'h00000, H,   H, 12'h100, L, 19'h0AAAA, 12'h100); // jump+ready
    v(H, L, 12'h000, H, 19'h03C3C, L,   L, 12'h100, H, 19'h03C3C, 12'h101);
    v(H, L, 12'h000, L, 19'h00000, H,   H, 12'h101, L, 19'h03C3C, 12'h101);
    v(H, H, 12'h7FF, L, 19'h00000, L,   H, 12'h101, L, 19'h03C3C, 12'h101); // pending jumps
    v(H, H, 12'h040, L, 19'h00000, L,   H, 12'h101, L, 19'h03C3C, 12'h101);
    v(H, L, 12'h000, L, 19'h00000, L,   H, 12'h101, L, 19'h03C3C, 12'h101);
    v(H, L, 12'h000, H, 19'h7FFFF, L,   H, 12'h040, L, 19'h03C3C, 12'h040); // discarded
    v(H, L, 12'h000, H, 19'h01111, L,   L, 12'h040, H, 19'h01111, 12'h041);
    v(H, L, 12'h000, L, 19'h00000, H,   H, 12'h041, L, 19'h01111, 12'h041);
    v(H, H, 12'h300, H, 19'h02222, L,   H, 12'h300, L, 19'h01111, 12'h300); // jump with ack
    v(H, L, 12'h000, H, 19'h03333, L,   L, 12'h300, H, 19'h03333, 12'h301);
    v(L, H, 12'h0AB, L, 19'h00000, L,   L, 12'h300, L, 19'h03333, 12'h0AB); // VALID jump, idle

    // Reset, first fetch and PC wrap on the RESET_PC=FFF instance.
    do_reset();
    drive(H, L, 12'h000, L, 19'h00000, L);
    check("wrap.req", 32'(w_mem_req), 32'(1'b1));
    check("wrap.addr0", 32'(w_mem_addr), 32'(12'hFFF));
    drive(H, L, 12'h000, H, 19'h1ABCD, L);
    check("wrap.vld", 32'(w_instr_valid), 32'(1'b1));
    check("wrap.pc", 32'(w_pc), 32'(12'h000));
    check("first.instr", 32'(INSTR), 32'(19'h1ABCD));
    drive(H, L, 12'h000, L, 19'h00000, H);
    check("wrap.addr1", 32'(w_mem_addr), 32'(12'h000));
    check("wrap.req1", 32'(w_mem_req), 32'(1'b1));

    // Cycle table.
    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].jmp, vecs[i].jaddr, vecs[i].ack, vecs[i].rdata, vecs[i].rdy);
      check($sformatf("row%0d.mem_req", i), 32'(mem_req), 32'(vecs[i].req));
      check($sformatf("row%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      check($sformatf("row%0d.instr_valid", i), 32'(instr_valid), 32'(vecs[i].vld));
      check($sformatf("row%0d.INSTR", i), 32'(INSTR), 32'(vecs[i].instr));
      check($sformatf("row%0d.pc", i), 32'(pc), 32'(vecs[i].pc));
    end

    // Asynchronous reset with a pending jump, then while an instruction is held.
    do_reset();
    drive(H, L, 12'h000, L, 19'h00000, L);
    drive(H, H, 12'h0F0, L, 19'h00000, L);
    @(negedge CLK);
    jump = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("arst.mem_req", 32'(mem_req), 32'(1'b0));
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("arst.refetch_addr", 32'(mem_addr), 32'(12'h000));
    check("arst.refetch_req", 32'(mem_req), 32'(1'b1));
    drive(H, L, 12'h000, H, 19'h0BEEF, L);
    check("arst.pend_cleared_vld", 32'(instr_valid), 32'(1'b1));
    check("arst.pend_cleared_instr", 32'(INSTR), 32'(19'h0BEEF));
    @(negedge CLK);
    mem_ack = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("arst.instr_valid", 32'(instr_valid), 32'(1'b0));
    RST = 1'b0;

    // Memory never acks.
    do_reset();
    drive(H, L, 12'h000, L, 19'h00000, L);
    for (int i = 1; i < 16; i++) begin
      drive(H, L, 12'h000, L, 19'h00000, L);
      check($sformatf("to.wait%0d.req", i), 32'(mem_req), 32'(1'b1));
      check($sformatf("to.wait%0d.err", i), 32'(fetch_error), 32'(1'b0));
    end
    drive(H, L, 12'h000, L, 19'h00000, L);
`ifdef FETCH_TIMEOUT_EN
    check("to.req", 32'(mem_req), 32'(1'b0));
    check("to.err", 32'(fetch_error), 32'(1'b1));
    drive(H, H, 12'h123, H, 19'h01234, H);
    drive(H, L, 12'h000, L, 19'h00000, L);
    check("to.sticky_err", 32'(fetch_error), 32'(1'b1));
    check("to.sticky_req", 32'(mem_req), 32'(1'b0));
    check("to.sticky_vld", 32'(instr_valid), 32'(1'b0));
`else
    check("to.req", 32'(mem_req), 32'(1'b1));
    check("to.err", 32'(fetch_error), 32'(1'b0));
    for (int i = 0; i < 8; i++) drive(H, L, 12'h000, L, 19'h00000, L);
    check("to.still_req", 32'(mem_req), 32'(1'b1));
    check("to.still_addr", 32'(mem_addr), 32'(12'h000));
`endif
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage feeding the instruction register. Holds the program counter and issues one read at a time to instruction memory over a req/ack handshake. Presents each fetched word on `INSTR` with a valid/ready handshake toward the instruction register and its load control. Accepts jump redirects from the control unit and flushes any in-flight or held instruction when one arrives.

## Interface
Parameters:
- `WORD_SIZE`, 19: instruction width.
- `ADDR_WIDTH`, 12: program-counter and memory address width.
- `RESET_PC`, 0: PC value after reset.
- `TIMEOUT_CYCLES`, 16: cycles in FETCH without `mem_ack` before error. Used only when timeout is compiled in.

Ports:
- `CLK` in 1: the single clock. All state changes on its rising edge.
- `RST` in 1: reset, asynchronous and active-high.
- `enable` in 1: run; when low, no new fetch starts.
- `jump` in 1: redirect strobe, one cycle.
- `jump_addr` in ADDR_WIDTH: redirect target.
- `mem_req` out 1: read request to instruction memory.
- `mem_addr` out ADDR_WIDTH: read address; stable while `mem_req`=1.
- `mem_ack` in 1: read data valid this cycle.
- `mem_rdata` in WORD_SIZE: read data.
- `INSTR` out WORD_SIZE: fetched instruction.
- `instr_valid` out 1: `INSTR` holds an unconsumed instruction.
- `instr_ready` in 1: the instruction register accepts `INSTR` this cycle.
- `pc` out ADDR_WIDTH: address of the next fetch.
- `fetch_error` out 1: sticky memory timeout flag.

## Operation
- **States:** IDLE, FETCH, VALID, and ERROR (ERROR only with `FETCH_TIMEOUT_EN`). All outputs are registered.
- **Reset values:**
  - State is IDLE.
  - `pc` and `mem_addr` are `RESET_PC`.
  - `mem_req`, `instr_valid` and `fetch_error` are 0.
  - `INSTR` is 0.
- **IDLE:**
  - With `enable`=1, go to FETCH. `mem_req` is set to 1 and `mem_addr` to `pc`.
  - `mem_ack` is ignored in IDLE. A stray ack after reset has no effect.
- **FETCH:**
  - `mem_req`=1 and `mem_addr` is held constant until ack.
  - On `mem_ack`:
    - `INSTR` is loaded from `mem_rdata`.
    - `instr_valid` is set to 1.
    - `pc` becomes `pc+1` modulo 2^ADDR_WIDTH, so `{ADDR_WIDTH{1'b1}}` wraps to 0.
    - `mem_req` is cleared. Go to VALID.
  - When `enable` drops in FETCH, the outstanding request still completes. It is never abandoned.
- **VALID:**
  - `INSTR` is held stable until `instr_valid && instr_ready`.
  - On that handshake, `instr_valid` is cleared. Go to FETCH if `enable`=1, otherwise IDLE.
- **Jump:**
  - In IDLE or VALID:
    - `pc` is set to `jump_addr` and `instr_valid` is cleared next cycle, even if `instr_ready`=1 in the same cycle.
    - From VALID, go to FETCH if `enable` is high, otherwise IDLE. From IDLE, follow the normal `enable` rule.
  - In FETCH without ack: the target is latched as pending. When ack arrives, the data is discarded, `pc` is set to the pending target, and the unit re-enters FETCH with the new address.
  - In FETCH with `mem_ack` in the same cycle: the data is discarded, `pc` is set to `jump_addr`, and the unit re-enters FETCH.
  - With two jumps before ack, the last one wins.
- **Asynchronous reset mid-operation:** `mem_req` and `instr_valid` drop immediately and the pending jump is cleared.

## Timing
- `enable` high in IDLE at edge 0 gives `mem_req`=1 after edge 0.
- `mem_ack` may come in the first cycle of `mem_req`. If the ack is sampled at edge 1, `instr_valid`=1 after edge 1.
- A handshake at edge 2 gives `mem_req`=1 after edge 2.
- Peak throughput is one instruction per 2 cycles.
- `pc` updates on the ack edge. A jump takes effect on the edge it is sampled.
- `mem_addr` changes only on the edge that sets `mem_req`.

## Configuration
- **`FETCH_TIMEOUT_EN` defined:**
  - A counter runs in FETCH and clears on ack, jump, or leaving FETCH.
  - After `TIMEOUT_CYCLES` consecutive FETCH cycles without ack:
    - `fetch_error` is set to 1.
    - `mem_req` is cleared and `instr_valid` stays 0.
    - The unit enters ERROR, which is left only by `RST`.
- **Not defined:** FETCH waits indefinitely, `fetch_error` is constant 0, and there is no ERROR state.

## Test plan
- **Reset and first fetch:** release `RST` with `enable`=1 and a zero-wait memory returning 19'h1ABCD at address 0. Expect `mem_addr`=0, `INSTR`=19'h1ABCD, `instr_valid` 2 edges after release, and `pc`=1.
- **Backpressure:** hold `instr_ready`=0 for 5 cycles. Expect `INSTR` and `instr_valid` stable and `mem_req`=0; after ready, the next `mem_addr`=`pc`.
- **PC wrap:** start at `RESET_PC`=12'hFFF. Expect a fetch at 12'hFFF, then `pc`=0 and the next `mem_addr`=0.
- **Jump during outstanding fetch:** `jump`=1 with `jump_addr`=12'h040 while the ack is delayed 3 cycles. Expect that data discarded, no `instr_valid`, and the next `mem_addr`=12'h040.
- **Jump with handshake:** `jump` and `instr_ready` in the same VALID cycle with `jump_addr`=12'h100. Expect `instr_valid`=0 next cycle, then a fetch at 12'h100.
- **Timeout (with `FETCH_TIMEOUT_EN`):** never ack. Expect `fetch_error`=1 and `mem_req`=0 after 16 FETCH cycles, the flag held until `RST`. Without the macro, `mem_req` stays 1 and `fetch_error`=0.
